// File: rtl/spi_byte_master.sv
// -----------------------------------------------------------------------------
// spi_byte_master
//
// SPI mode-0 byte master. It accepts one byte at a time on a valid/ready
// handshake and shifts it out MSB first on sdo. At the same time it shifts
// sdi into a receive register and reports each received byte on a one-cycle
// rx_valid pulse. Bytes sent back-to-back without tx_last share one
// chip-select frame. The block idles in WAIT between such bytes with csb
// still low. A byte marked tx_last closes the frame after a hold time of
// one SCK half-period.
//
// Ports
//   clock     system clock; all logic uses its rising edge
//   resetn    asynchronous active-low reset
//   div       SCK half-period minus one, in clock cycles
//   tx_valid  a transmit byte is offered
//   tx_ready  the offered byte is taken on this cycle's edge
//   tx_data   byte to send, MSB first
//   tx_last   release csb after this byte
//   abort     synchronous cancel of the current transfer
//   rx_valid  one-cycle pulse: rx_data holds a completed byte
//   rx_data   last received byte, held until the next rx_valid
//   sck, csb, sdo, sdoenb (active-low sdo enable), sdi: SPI pins
// -----------------------------------------------------------------------------
module spi_byte_master #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [7:0]           tx_data,
    input  logic                 tx_last,
    input  logic                 abort,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic                 sck,
    output logic                 csb,
    output logic                 sdo,
    output logic                 sdoenb,
    input  logic                 sdi
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t               state_q,    state_d;
    logic [DIV_WIDTH-1:0] hdiv_q,     hdiv_d;     // latched div, so H = hdiv_q + 1
    logic [DIV_WIDTH-1:0] cnt_q,      cnt_d;      // cycles elapsed in the current half-period
    logic [2:0]           fall_q,     fall_d;     // SCK falls already completed in this byte
    logic                 last_q,     last_d;
    logic [7:0]           tx_sh_q,    tx_sh_d;
    logic [7:0]           rx_sh_q,    rx_sh_d;
    logic                 sck_q,      sck_d;
    logic                 csb_q,      csb_d;
    logic                 sdo_q,      sdo_d;
    logic                 sdoenb_q,   sdoenb_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q,  rx_data_d;

    logic accept;
    logic half_tick;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        hdiv_d     = hdiv_q;
        cnt_d      = cnt_q;
        fall_d     = fall_q;
        last_d     = last_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        sck_d      = sck_q;
        csb_d      = csb_q;
        sdo_d      = sdo_q;
        sdoenb_d   = sdoenb_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        // abort takes priority over the handshake, so no byte is taken with it
        accept    = tx_valid && tx_ready_q && !abort;
        // Last cycle of a half-period. H = hdiv_q + 1 reaches 2^DIV_WIDTH
        // without a wider counter.
        half_tick = (cnt_q == hdiv_q);

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (accept) begin
                    // The divider is sampled only at the start of a frame.
                    // A burst keeps the H it started with.
                    if (state_q == ST_IDLE) begin
                        hdiv_d = div;
                    end
                    tx_sh_d  = tx_data;
                    sdo_d    = tx_data[7];
                    last_d   = tx_last;
                    csb_d    = 1'b0;
                    sdoenb_d = 1'b0;
                    cnt_d    = '0;
                    fall_d   = '0;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                cnt_d = half_tick ? '0 : cnt_q + 1'b1;
                if (half_tick) begin
                    if (!sck_q) begin
                        // Rising edge: sample the slave.
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], sdi};
                    end else begin
                        sck_d = 1'b0;
                        if (fall_q == 3'd7) begin
                            // Eighth fall. All 8 bits were sampled on the
                            // rises, so the byte is complete. sdo keeps bit 0.
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_sh_q;
                            fall_d     = '0;
                            state_d    = last_q ? ST_HOLD : ST_WAIT;
                        end else begin
                            fall_d  = fall_q + 3'd1;
                            sdo_d   = tx_sh_q[6];
                            tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        end
                    end
                end
            end

            ST_HOLD: begin
                // Keep csb low for one more half-period after the last fall.
                cnt_d = half_tick ? '0 : cnt_q + 1'b1;
                if (half_tick) begin
                    csb_d    = 1'b1;
                    sdoenb_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A cancel overrides everything the case decided on this edge. That
        // includes a byte completing on the same edge.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            csb_d      = 1'b1;
            sck_d      = 1'b0;
            sdoenb_d   = 1'b1;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
            cnt_d      = '0;
            fall_d     = '0;
        end

        // tx_ready is registered from the state being entered. It is
        // therefore low during reset and rises on the first edge afterwards.
        tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its *_d input.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            hdiv_q     <= '0;
            cnt_q      <= '0;
            fall_q     <= '0;
            last_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            sck_q      <= 1'b0;
            csb_q      <= 1'b1;
            sdo_q      <= 1'b0;
            sdoenb_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hdiv_q     <= hdiv_d;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
            last_q     <= last_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            sck_q      <= sck_d;
            csb_q      <= csb_d;
            sdo_q      <= sdo_d;
            sdoenb_q   <= sdoenb_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // All outputs come straight from flops, so the SPI pins are glitch-free.
    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sck      = sck_q;
    assign csb      = csb_q;
    assign sdo      = sdo_q;
    assign sdoenb   = sdoenb_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_master
//
// Scoreboard bench for spi_byte_master. Stimulus pushes the expected MOSI byte
// and the expected MISO byte into queues. Two monitors pop and compare:
//   - the pin monitor rebuilds each byte from sdo on SCK rising edges;
//   - the rx monitor compares rx_data on each rx_valid pulse.
// The slave is modelled from the bit position alone. In byte n it drives bit
// (7 - falls since acceptance) of its chosen byte. In loopback mode sdi
// follows sdo.
// -----------------------------------------------------------------------------
module tb_spi_byte_master;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] div;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_last;
    logic          abort;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          sck, csb, sdo, sdoenb, sdi;

    spi_byte_master #(.DIV_WIDTH(DW)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .div      (div),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .abort    (abort),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .sck      (sck),
        .csb      (csb),
        .sdo      (sdo),
        .sdoenb   (sdoenb),
        .sdi      (sdi)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Count of rising clock edges; the edge with number N is "cycle N".
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic       loopback = 1'b1;
    logic [7:0] slave_cur = 8'h00;
    int         slave_base = 0;
    int         sck_falls = 0;
    int         sck_rises = 0;
    int         csb_rises = 0;
    int         sidx;
    logic       sdi_slave;

    always @(negedge sck) sck_falls <= sck_falls + 1;
    always @(posedge sck) sck_rises <= sck_rises + 1;
    always @(posedge csb) csb_rises <= csb_rises + 1;

    always_comb begin
        sidx = sck_falls - slave_base;
        if (sidx > 7) sidx = 7;
        if (sidx < 0) sidx = 0;
        sdi_slave = slave_cur[7 - sidx];
    end
    assign sdi = loopback ? sdo : sdi_slave;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    int         rx_count = 0;
    int         rx_cyc   = 0;

    // Rebuild each MOSI byte from sdo as the slave would see it.
    logic [7:0] cap = 8'h00;
    int         ncap = 0;
    always @(posedge sck or posedge csb) begin
        if (csb) begin
            ncap = 0;
        end else begin
            cap = {cap[6:0], sdo};
            ncap++;
            if (ncap == 8) begin
                ncap = 0;
                check("sdo_byte_expected", exp_tx_q.size() != 0, 1);
                if (exp_tx_q.size() != 0) check("sdo_byte", cap, exp_tx_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (rx_valid) begin
            rx_count++;
            rx_cyc = cyc;
            check("rx_valid_expected", exp_rx_q.size() != 0, 1);
            if (exp_rx_q.size() != 0) check("rx_data", rx_data, exp_rx_q.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge. Offers a byte, predicts the edge that accepts it,
    // and returns at the negedge after that edge with tx_valid still high.
    task automatic send(input logic [7:0] data, input logic last, input logic lb,
                        input logic [7:0] sbyte, input logic expect_done, output int acc);
        tx_data  = data;
        tx_last  = last;
        tx_valid = 1'b1;
        for (int t = 0; t < 20000 && !tx_ready; t++) @(negedge clock);
        if (!tx_ready) check("accept_timeout", tx_ready, 1);
        acc        = cyc + 1;
        loopback   = lb;
        slave_cur  = sbyte;
        slave_base = sck_falls;
        if (expect_done) begin
            exp_tx_q.push_back(data);
            exp_rx_q.push_back(lb ? data : sbyte);
        end
        @(negedge clock);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 20000; t++) begin
            if (csb && tx_ready && exp_rx_q.size() == 0 && exp_tx_q.size() == 0) break;
            @(negedge clock);
        end
        check("frame_closed_csb", csb, 1);
        check("rx_drained", exp_rx_q.size(), 0);
    endtask

    task automatic wait_rx(input int base);
        for (int t = 0; t < 20000 && rx_count <= base; t++) @(negedge clock);
        check("rx_arrived", rx_count > base, 1);
        @(negedge clock);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // ---------------- test sequence ----------------
    int acc;
    int r0, c0, rc0, viol, sdo_hi;

    initial begin
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; abort = 1'b0; div = '0;

        // Reset state
        #12;
        check("rst_csb", csb, 1);
        check("rst_sck", sck, 0);
        check("rst_sdo", sdo, 0);
        check("rst_sdoenb", sdoenb, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        @(negedge clock); resetn = 1'b1;
        @(negedge clock);
        check("tx_ready_after_reset", tx_ready, 1);

        // Loopback, div=0, 0x93: rx_valid on cycle 16, csb high on cycle 17.
        div = '0; r0 = sck_rises;
        send(8'h93, 1'b1, 1'b1, 8'h00, 1'b1, acc); tx_valid = 1'b0;
        wait_cyc(acc + 16);
        check("d0_rx_valid_at_16", rx_valid, 1);
        check("d0_csb_low_at_16", csb, 0);
        @(negedge clock);
        check("d0_csb_high_at_17", csb, 1);
        check("d0_rx_cycle", rx_cyc - acc, 16);
        check("d0_sck_pulses", sck_rises - r0, 8);
        wait_done();

        // sdi tied high, div=3, 0x00: H=4, rx at cycle 64, sdo low throughout.
        div = DW'(3); r0 = sck_rises; sdo_hi = 0;
        send(8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, acc); tx_valid = 1'b0;
        while (cyc < acc + 64) begin
            if (sdo) sdo_hi++;
            if (cyc == acc + 3) check("d3_sck_low_at_3", sck, 0);
            if (cyc == acc + 4) check("d3_sck_high_at_4", sck, 1);
            @(negedge clock);
        end
        check("d3_rx_valid_at_64", rx_valid, 1);
        check("d3_sdo_never_high", sdo_hi, 0);
        wait_done();
        check("d3_sck_pulses", sck_rises - r0, 8);

        // Burst 0x01, 0x00, 0x13 with tx_valid held: one frame of 24 pulses.
        div = '0; r0 = sck_rises; c0 = csb_rises;
        send(8'h01, 1'b0, 1'b1, 8'h00, 1'b1, acc);
        send(8'h00, 1'b0, 1'b1, 8'h00, 1'b1, acc);
        send(8'h13, 1'b1, 1'b1, 8'h00, 1'b1, acc);
        tx_valid = 1'b0;
        wait_done();
        check("burst_sck_pulses", sck_rises - r0, 24);
        check("burst_single_csb_release", csb_rises - c0, 1);

        // Pause in WAIT for 100 cycles, then 0x57.
        div = DW'(1); rc0 = rx_count; viol = 0;
        send(8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, acc); tx_valid = 1'b0;
        wait_rx(rc0);
        check("wait_tx_ready", tx_ready, 1);
        repeat (100) begin
            if (csb !== 1'b0 || sck !== 1'b0) viol++;
            @(negedge clock);
        end
        check("wait_pins_held", viol, 0);
        send(8'h57, 1'b1, 1'b1, 8'h00, 1'b1, acc); tx_valid = 1'b0;
        wait_done();
        check("wait_rx_data_after", rx_data, 8'h57);

        // Abort on cycle 5 of a div=0 byte; then abort against tx_valid in IDLE.
        div = '0; rc0 = rx_count;
        send(8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, acc); tx_valid = 1'b0;
        wait_cyc(acc + 4);
        abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        check("abort_csb", csb, 1);
        check("abort_sck", sck, 0);
        check("abort_sdoenb", sdoenb, 1);
        tx_data = 8'hFF; tx_valid = 1'b1; abort = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0; abort = 1'b0;
        check("abort_beats_valid_csb", csb, 1);
        repeat (30) @(negedge clock);
        check("abort_no_rx", rx_count - rc0, 0);
        send(8'hB5, 1'b1, 1'b1, 8'h00, 1'b1, acc); tx_valid = 1'b0;
        wait_done();

        // Reset pulse in the middle of a byte.
        div = DW'(2); rc0 = rx_count;
        send(8'h6E, 1'b1, 1'b1, 8'h00, 1'b0, acc); tx_valid = 1'b0;
        repeat (10) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst_csb", csb, 1);
        check("midrst_sck", sck, 0);
        check("midrst_sdo", sdo, 0);
        check("midrst_sdoenb", sdoenb, 1);
        check("midrst_tx_ready", tx_ready, 0);
        check("midrst_rx_data", rx_data, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("midrst_tx_ready_back", tx_ready, 1);
        repeat (40) @(negedge clock);
        check("midrst_no_rx", rx_count - rc0, 0);
        send(8'h23, 1'b1, 1'b1, 8'h00, 1'b1, acc); tx_valid = 1'b0;
        wait_done();

        // Maximum divider: H = 2^DW, byte completes at 16*H.
        div = '1; rc0 = rx_count;
        send(8'hC6, 1'b1, 1'b0, 8'h9A, 1'b1, acc); tx_valid = 1'b0;
        wait_rx(rc0);
        check("maxdiv_rx_cycle", rx_cyc - acc, 16 * (1 << DW));
        wait_done();

        // Randomised frames: 1..3 bytes with gaps, random slave or loopback.
        // div also changes mid-frame; the DUT must ignore that.
        for (int f = 0; f < 12; f++) begin
            int nb;
            nb  = $urandom_range(1, 3);
            div = DW'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                logic [7:0] d, s;
                logic       lb;
                int         gap;
                d   = 8'($urandom);
                s   = 8'($urandom);
                lb  = 1'($urandom_range(0, 1));
                gap = $urandom_range(0, 3);
                if (b > 0 && gap > 0) begin
                    tx_valid = 1'b0;
                    repeat (gap) @(negedge clock);
                end
                send(d, (b == nb - 1), lb, s, 1'b1, acc);
                if (b == 0) div = DW'($urandom_range(0, 3));
            end
            tx_valid = 1'b0;
            wait_done();
        end

        check("tx_queue_drained", exp_tx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 8, meaning the width of the clock-divider input.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port div, input, DIV_WIDTH bits: SCK half-period minus one, in clock cycles.
REQ-005 The block SHALL have port tx_valid, input, 1 bit: a transmit byte is offered.
REQ-006 The block SHALL have port tx_ready, output, 1 bit: the block accepts the offered byte this cycle.
REQ-007 The block SHALL have port tx_data, input, 8 bits: the byte to shift out, MSB first.
REQ-008 The block SHALL have port tx_last, input, 1 bit: release CSB after this byte.
REQ-009 The block SHALL have port abort, input, 1 bit: synchronous transfer cancel.
REQ-010 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking a completed received byte.
REQ-011 The block SHALL have port rx_data, output, 8 bits: the received byte, held until the next rx_valid.
REQ-012 The block SHALL have ports sck (output, 1 bit), csb (output, 1 bit), sdo (output, 1 bit), sdoenb (output, 1 bit, active-low SDO enable) and sdi (input, 1 bit), forming the SPI pins.

Function
REQ-013 The block SHALL operate in SPI mode 0 only: idle SCK low, SDI sampled on the SCK rising edge, SDO changed on the SCK falling edge.
REQ-014 The block SHALL implement states IDLE, SHIFT, WAIT and HOLD.
REQ-015 The block SHALL drive tx_ready high only in IDLE and WAIT; a byte is accepted when tx_valid and tx_ready are both high.
REQ-016 On acceptance in IDLE the block SHALL latch div as H = div+1, drive csb=0, sdoenb=0, sdo=tx_data[7], latch tx_last, and enter SHIFT.
REQ-017 Changes to div SHALL be ignored until the next acceptance made from IDLE.
REQ-018 In SHIFT, taking the acceptance edge as t=0, SCK SHALL rise at t=H(2k+1) and fall at t=H(2k+2) for k=0..7.
REQ-019 On each SCK rise the block SHALL shift sdi into the receive register.
REQ-020 On each SCK fall except the 8th the block SHALL present the next lower tx bit on sdo.
REQ-021 At t=16H the block SHALL pulse rx_valid for exactly one cycle, with rx_data valid in that same cycle.
REQ-022 rx_valid SHALL have no backpressure; an unread byte is overwritten by the next one.
REQ-023 After the 8th fall, if the latched last flag is 0 the block SHALL enter WAIT with csb held low, sck=0 and sdo holding bit 0.
REQ-024 On acceptance in WAIT the block SHALL load the new byte, keep the same H, and re-enter SHIFT exactly as REQ-016 except that csb stays low.
REQ-025 WAIT SHALL persist indefinitely, with no timeout.
REQ-026 After the 8th fall, if the latched last flag is 1 the block SHALL enter HOLD for H cycles, then drive csb=1 and sdoenb=1 and enter IDLE.
REQ-027 tx_ready SHALL be low throughout HOLD.
REQ-028 abort high in any state other than IDLE SHALL, on the next edge, force IDLE with csb=1, sck=0 and sdoenb=1, and suppress any rx_valid from that edge onward.
REQ-029 If abort and tx_valid are high in the same cycle, abort SHALL win and no byte is accepted.
REQ-030 When div=0 the block SHALL produce SCK at clock/2 with no dead cycle; div at its maximum value SHALL give H=2^DIV_WIDTH without counter overflow.

Reset
REQ-031 While resetn=0 the block SHALL asynchronously force the IDLE state, csb=1, sck=0, sdo=0, sdoenb=1, tx_ready=0, rx_valid=0 and rx_data=0x00, and clear all counters.
REQ-032 tx_ready SHALL rise on the first clock edge after resetn deasserts.
REQ-033 A reset mid-transfer SHALL truncate the SPI frame immediately, produce no rx_valid, and emit no glitch on csb.

Verification
REQ-034 Loopback (sdi=sdo), div=0, tx_data=0x93, tx_last=1 -> rx_valid at cycle 16 with rx_data=0x93; csb high at cycle 17.
REQ-035 sdi tied to 1, div=3, tx_data=0x00, tx_last=1 -> SCK half-period 4 cycles, 8 SCK pulses, rx_data=0xFF at cycle 64, sdo low throughout.
REQ-036 Loopback burst of 0x01, 0x00, 0x13 with tx_last only on the 3rd byte, tx_valid held high -> csb low continuously for 24 SCK pulses and rx_data sequence 0x01, 0x00, 0x13.
REQ-037 Burst paused in WAIT for 100 cycles, then byte 0x57 -> csb stays low and sck stays 0 during the pause; rx_data=0x57 afterwards.
REQ-038 abort at cycle 5 of a div=0 byte -> csb=1 and sck=0 at cycle 6, no rx_valid, next byte 0xB5 completes correctly.
REQ-039 resetn pulsed low mid-byte -> all outputs at reset values asynchronously and no rx_valid; a subsequent 0x23 loopback returns 0x23.
